// File: rtl/erp_pkg.sv
// Shared helpers for the elastic register pipeline: occupancy counter width
// and parameter legality.
package erp_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 32'sd1);
    endfunction

    function automatic bit cfg_legal(input int depth, input int width);
        return (depth >= 32'sd1) && (width >= 32'sd1);
    endfunction

endpackage

// File: rtl/elastic_reg_pipe_if.sv
// Valid/ready stream channel; master drives valid/data, slave drives ready.
interface elastic_reg_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/erp_stage.sv
// One pipeline stage: data/valid registers, local accept/advance decode and
// the load mux.
module erp_stage
    import erp_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_acc,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             adv
);

    logic             vld_r;
    logic [WIDTH-1:0] data_r;
    logic             acc_s;
    logic             load_s;

    // Advance/accept decode; for k>0 the upstream advance already implies acc_s.
    always_comb begin
        adv    = vld_r & down_acc;
        acc_s  = ~vld_r | adv;
        load_s = up_valid & acc_s;
    end

    // Stage registers: flush beats load, load beats drain; data only moves on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r  <= 1'b0;
            data_r <= INIT;
        end else if (flush) begin
            vld_r  <= 1'b0;
            data_r <= INIT;
        end else if (load_s) begin
            vld_r  <= 1'b1;
            data_r <= up_data;
        end else if (adv) begin
            vld_r  <= 1'b0;
        end
    end

    assign vld  = vld_r;
    assign data = data_r;

endmodule

// File: rtl/elastic_reg_pipe.sv
// DEPTH-stage elastic register pipeline with bubble collapse, synchronous
// flush and a registered occupancy count.
module elastic_reg_pipe
    import erp_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    elastic_reg_pipe_if.slave       up,
    elastic_reg_pipe_if.master      down,
    output logic [cnt_w(DEPTH)-1:0] occupancy
);

    localparam int CW = cnt_w(DEPTH);

    if (!cfg_legal(DEPTH, WIDTH)) begin : g_bad_cfg
        $error("elastic_reg_pipe: DEPTH and WIDTH must both be >= 1");
    end

    logic [DEPTH-1:0]            vld_s;
    logic [DEPTH-1:0][WIDTH-1:0] data_s;
    logic [DEPTH-1:0]            adv_s;
    logic [DEPTH:0]              acc_s;
    logic                        in_ready_s;
    logic                        push_s;
    logic                        pop_s;

    // acc[k] unrolled: stage k can take an item unless it and every stage
    // after it are full while the sink stalls. Built only from registered
    // valids, so the ready path has no combinational chain through acc_s.
    assign acc_s[DEPTH] = down.ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid_s;
        logic [WIDTH-1:0] up_data_s;

        assign acc_s[k] = down.ready | ~(&vld_s[DEPTH-1:k]);

        if (k == 0) begin : g_head
            assign up_valid_s = up.valid;
            assign up_data_s  = up.data;
        end else begin : g_body
            assign up_valid_s = adv_s[k-1];
            assign up_data_s  = data_s[k-1];
        end

        erp_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (up_valid_s),
            .up_data  (up_data_s),
            .down_acc (acc_s[k+1]),
            .vld      (vld_s[k]),
            .data     (data_s[k]),
            .adv      (adv_s[k])
        );
    end

    assign in_ready_s = acc_s[0] & ~flush;
    assign push_s     = up.valid & in_ready_s;
    assign pop_s      = adv_s[DEPTH-1];

    assign up.ready   = in_ready_s;
    assign down.valid = vld_s[DEPTH-1];
    assign down.data  = data_s[DEPTH-1];

    // Occupancy tracks the valid bits: +1 per accept, -1 per pop, 0 on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= {CW{1'b0}};
        end else if (flush) begin
            occupancy <= {CW{1'b0}};
        end else begin
            occupancy <= occupancy + CW'(push_s) - CW'(pop_s);
        end
    end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Bench for elastic_reg_pipe: queue-based position model per instance plus
// directed literal checks on the DEPTH=3 / WIDTH=8 / INIT=A5 instance.
module tb_elastic_reg_pipe;
    import erp_pkg::*;

    localparam int NI = 4;

    function automatic int dep_of(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            2:       return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int wid_of(input int g);
        case (g)
            0:       return 8;
            1:       return 1;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid_t  [NI];
    logic [31:0] in_data_t   [NI];
    logic        out_ready_t [NI];
    logic        flush_t     [NI];
    logic        out_valid_t [NI];
    logic [31:0] out_data_t  [NI];
    logic        in_ready_t  [NI];
    int          occ_t       [NI];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int             D  = dep_of(g);
        localparam int             W  = wid_of(g);
        localparam logic [W-1:0]   IV = W'(32'hA5);

        elastic_reg_pipe_if #(.WIDTH(W)) up_if ();
        elastic_reg_pipe_if #(.WIDTH(W)) dn_if ();
        logic [cnt_w(D)-1:0] occ_s;

        elastic_reg_pipe #(
            .WIDTH (W),
            .DEPTH (D),
            .INIT  (IV)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush_t[g]),
            .up        (up_if),
            .down      (dn_if),
            .occupancy (occ_s)
        );

        assign up_if.valid    = in_valid_t[g];
        assign up_if.data     = in_data_t[g][W-1:0];
        assign dn_if.ready    = out_ready_t[g];
        assign out_valid_t[g] = dn_if.valid;
        assign out_data_t[g]  = 32'(dn_if.data);
        assign in_ready_t[g]  = up_if.ready;
        assign occ_t[g]       = int'(occ_s);

        // Model: ordered items with their stage position; items drift toward the
        // output until they touch the item ahead, head leaves from D-1 on ready.
        logic [W-1:0] md [$];
        int           mp [$];
        bit           ev;
        bit           er;
        int           lim;

        always @(negedge clk) begin
            if (rst) begin
                md.delete();
                mp.delete();
            end else begin
                ev = (mp.size() > 0) && (mp[0] == D - 1);
                er = !flush_t[g] && ((md.size() < D) || out_ready_t[g]);
                chk($sformatf("i%0d_out_valid", g), 32'(out_valid_t[g]), 32'(ev));
                chk($sformatf("i%0d_in_ready", g), 32'(in_ready_t[g]), 32'(er));
                chk($sformatf("i%0d_occupancy", g), 32'(occ_t[g]), 32'(md.size()));
                if (ev) chk($sformatf("i%0d_out_data", g), out_data_t[g], 32'(md[0]));
                if (flush_t[g]) begin
                    md.delete();
                    mp.delete();
                end else begin
                    if (ev && out_ready_t[g]) begin
                        void'(md.pop_front());
                        void'(mp.pop_front());
                    end
                    lim = D - 1;
                    for (int i = 0; i < mp.size(); i++) begin
                        mp[i] = (mp[i] + 1 < lim) ? mp[i] + 1 : lim;
                        lim   = mp[i] - 1;
                    end
                    if (in_valid_t[g] && er) begin
                        md.push_back(in_data_t[g][W-1:0]);
                        mp.push_back(0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] d);
        in_valid_t[0] = 1'b1;
        in_data_t[0]  = d;
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            in_valid_t[g]  = 1'b0;
            in_data_t[g]   = 32'h0;
            out_ready_t[g] = 1'b0;
            flush_t[g]     = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready_t[0]), 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid_t[0]), 32'h0);
        chk("rst_out_data", out_data_t[0], 32'hA5);
        chk("rst_occ", 32'(occ_t[0]), 32'h0);
        tick();

        // Latency: one item through three stages, then a 16-item stream.
        out_ready_t[0] = 1'b1;
        push0(32'h11);
        tick();
        in_valid_t[0] = 1'b0;
        chk("lat_e0_valid", 32'(out_valid_t[0]), 32'h0);
        tick();
        chk("lat_e1_valid", 32'(out_valid_t[0]), 32'h0);
        tick();
        chk("lat_e2_valid", 32'(out_valid_t[0]), 32'h1);
        chk("lat_e2_data", out_data_t[0], 32'h11);
        for (int i = 0; i < 16; i++) begin
            push0(32'(i));
            tick();
            if (i >= 2) begin
                chk("stream_valid", 32'(out_valid_t[0]), 32'h1);
                chk("stream_data", out_data_t[0], 32'(i - 2));
            end
        end
        in_valid_t[0] = 1'b0;
        tick();
        chk("stream_tail0", out_data_t[0], 32'h0E);
        tick();
        chk("stream_tail1", out_data_t[0], 32'h0F);
        tick();
        chk("stream_empty_valid", 32'(out_valid_t[0]), 32'h0);
        chk("stream_empty_occ", 32'(occ_t[0]), 32'h0);

        // Fill and stall, then pop and push together on a full pipe.
        out_ready_t[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push0(32'h21 + 32'(i));
            #1;
            chk("fill_in_ready", 32'(in_ready_t[0]), 32'h1);
            tick();
        end
        push0(32'h24);
        #1;
        chk("full_in_ready", 32'(in_ready_t[0]), 32'h0);
        chk("full_occ", 32'(occ_t[0]), 32'h3);
        chk("full_data", out_data_t[0], 32'h21);
        tick();
        chk("stall_occ", 32'(occ_t[0]), 32'h3);
        chk("stall_data", out_data_t[0], 32'h21);
        out_ready_t[0] = 1'b1;
        #1;
        chk("popush_in_ready", 32'(in_ready_t[0]), 32'h1);
        tick();
        in_valid_t[0] = 1'b0;
        chk("popush_occ", 32'(occ_t[0]), 32'h3);
        chk("popush_data", out_data_t[0], 32'h22);
        tick();
        chk("drain_23", out_data_t[0], 32'h23);
        chk("drain_occ2", 32'(occ_t[0]), 32'h2);
        tick();
        chk("drain_24", out_data_t[0], 32'h24);
        tick();
        chk("drain_empty", 32'(occ_t[0]), 32'h0);

        // Bubble collapse: A, gap, B with the sink stalled.
        out_ready_t[0] = 1'b0;
        push0(32'hAA);
        tick();
        in_valid_t[0] = 1'b0;
        tick();
        push0(32'hBB);
        tick();
        in_valid_t[0] = 1'b0;
        tick();
        chk("bubble_occ", 32'(occ_t[0]), 32'h2);
        chk("bubble_in_ready", 32'(in_ready_t[0]), 32'h1);
        chk("bubble_head", out_data_t[0], 32'hAA);
        out_ready_t[0] = 1'b1;
        tick();
        chk("bubble_next", out_data_t[0], 32'hBB);
        chk("bubble_next_valid", 32'(out_valid_t[0]), 32'h1);
        tick();
        chk("bubble_empty", 32'(occ_t[0]), 32'h0);

        // Flush a full pipe while offering an item.
        out_ready_t[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push0(32'h31 + 32'(i));
            tick();
        end
        in_valid_t[0] = 1'b0;
        chk("preflush_occ", 32'(occ_t[0]), 32'h3);
        flush_t[0] = 1'b1;
        push0(32'h44);
        #1;
        chk("flush_in_ready", 32'(in_ready_t[0]), 32'h0);
        tick();
        flush_t[0]    = 1'b0;
        in_valid_t[0] = 1'b0;
        chk("flush_occ", 32'(occ_t[0]), 32'h0);
        chk("flush_valid", 32'(out_valid_t[0]), 32'h0);
        chk("flush_data", out_data_t[0], 32'hA5);
        tick();
        chk("flush_no_accept", 32'(occ_t[0]), 32'h0);

        // Asynchronous reset in the middle of a cycle.
        push0(32'h51);
        tick();
        push0(32'h52);
        tick();
        in_valid_t[0] = 1'b0;
        chk("prerst_occ", 32'(occ_t[0]), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid_t[0]), 32'h0);
        chk("arst_data", out_data_t[0], 32'hA5);
        chk("arst_occ", 32'(occ_t[0]), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_occ", 32'(occ_t[0]), 32'h0);

        // Random valid/ready/flush traffic on the other configurations.
        out_ready_t[0] = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int g = 1; g < NI; g++) begin
                in_valid_t[g]  = ($urandom_range(0, 3) != 0);
                in_data_t[g]   = $urandom;
                out_ready_t[g] = ($urandom_range(0, 3) < ((cyc < 200) ? 1 : 3));
                flush_t[g]     = ((cyc % 97) == 50);
            end
            tick();
        end
        for (int g = 1; g < NI; g++) begin
            in_valid_t[g]  = 1'b0;
            out_ready_t[g] = 1'b1;
            flush_t[g]     = 1'b0;
        end
        repeat (8) tick();
        for (int g = 1; g < NI; g++) begin
            chk($sformatf("i%0d_drained", g), 32'(occ_t[g]), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
